// File: rtl/fifo_frame_packer_if.sv
// rtl/fifo_frame_packer_if.sv - FIFO read-side and byte-stream signal bundle for fifo_frame_packer
interface fifo_frame_packer_if;
    logic        fifo_rd_vld;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  fifo_rd_vld,
        input  fifo_rd_data,
        input  tx_ready,
        output fifo_rd_en,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output fifo_rd_vld,
        output fifo_rd_data,
        output tx_ready,
        input  fifo_rd_en,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/fifo_frame_packer.sv
// rtl/fifo_frame_packer.sv - packs FWFT 16-bit words into AA 55 len payload [csum] byte frames
// Trailing checksum byte is built only when FRAME_PACKER_CSUM_EN is defined.
module fifo_frame_packer #(
    parameter int unsigned FRAME_WORDS = 256,
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h55
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    fifo_frame_packer_if.master        bus,
    output logic                       busy,
    output logic [15:0]                frame_cnt
);
    localparam logic [15:0] LEN_BYTES = 16'(2 * FRAME_WORDS);
    localparam logic [14:0] LAST_WORD = 15'(FRAME_WORDS - 1);

`ifdef FRAME_PACKER_CSUM_EN
    typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, LEN_H, LEN_L, PAY_H, PAY_L, CSUM} state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, LEN_H, LEN_L, PAY_H, PAY_L} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    state_t      step_nxt;
    logic [14:0] word_cnt;
    logic        load;
    logic        byte_avail;
    logic        byte_load;
    logic [7:0]  byte_val;
    logic        last_word;
    logic        frame_done;

    // The output register may take a new byte whenever it is empty or being drained.
    assign load      = !bus.tx_valid || bus.tx_ready;
    assign last_word = (word_cnt == LAST_WORD);

    always_comb begin
        byte_avail = 1'b0;
        byte_val   = 8'h00;
        step_nxt   = state;
        case (state)
            SYNC0: begin
                byte_avail = 1'b1;
                byte_val   = HDR0;
                step_nxt   = SYNC1;
            end
            SYNC1: begin
                byte_avail = 1'b1;
                byte_val   = HDR1;
                step_nxt   = LEN_H;
            end
            LEN_H: begin
                byte_avail = 1'b1;
                byte_val   = LEN_BYTES[15:8];
                step_nxt   = LEN_L;
            end
            LEN_L: begin
                byte_avail = 1'b1;
                byte_val   = LEN_BYTES[7:0];
                step_nxt   = PAY_H;
            end
            PAY_H: begin
                byte_avail = bus.fifo_rd_vld;
                byte_val   = bus.fifo_rd_data[15:8];
                step_nxt   = PAY_L;
            end
            PAY_L: begin
                byte_avail = bus.fifo_rd_vld;
                byte_val   = bus.fifo_rd_data[7:0];
`ifdef FRAME_PACKER_CSUM_EN
                step_nxt   = last_word ? CSUM : PAY_H;
`else
                step_nxt   = last_word ? IDLE : PAY_H;
`endif
            end
`ifdef FRAME_PACKER_CSUM_EN
            CSUM: begin
                byte_avail = 1'b1;
                byte_val   = csum;
                step_nxt   = IDLE;
            end
`endif
            default: begin
                byte_avail = 1'b0;
                byte_val   = 8'h00;
                step_nxt   = state;
            end
        endcase

        byte_load = load && byte_avail;

        // Frame start is the only move that does not ride on a byte load.
        if (state == IDLE) begin
            state_nxt = (enable && bus.fifo_rd_vld) ? SYNC0 : IDLE;
        end else begin
            state_nxt = byte_load ? step_nxt : state;
        end
    end

    assign bus.fifo_rd_en = byte_load && (state == PAY_L);
    assign busy           = (state != IDLE) || bus.tx_valid;

`ifdef FRAME_PACKER_CSUM_EN
    assign frame_done = byte_load && (state == CSUM);
`else
    assign frame_done = byte_load && (state == PAY_L) && last_word;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_data  <= 8'h00;
            bus.tx_valid <= 1'b0;
        end else if (load) begin
            bus.tx_valid <= byte_avail;
            if (byte_avail) begin
                bus.tx_data <= byte_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 15'd0;
        end else if (byte_load && (state == SYNC0)) begin
            word_cnt <= 15'd0;
        end else if (byte_load && (state == PAY_L)) begin
            word_cnt <= word_cnt + 15'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'h0000;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'h0001;
        end
    end

`ifdef FRAME_PACKER_CSUM_EN
    // Only payload bytes enter the sum; SYNC0 restarts it for every frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (byte_load) begin
            if (state == SYNC0) begin
                csum <= 8'h00;
            end else if ((state == PAY_H) || (state == PAY_L)) begin
                csum <= csum + byte_val;
            end
        end
    end
`endif
endmodule
